// File: rtl/fc_control_seq.sv
// fc_control_seq
// ----------------------------------------------------------------------------
// Sequencer for one fully-connected layer pass. After a `start` pulse it walks
// every (group, pair) issue slot once, one pair per cycle. For each slot it
// generates:
//   - input-neuron and weight M9K addresses for ports a and b;
//   - the PI-way bank select, delayed to line up with returning read data;
//   - MAC accumulator strobes (enable_mult, accum_sload);
//   - output-neuron write strobes (out_wr, out_addr).
//
// Handshake: `start` is sampled only in IDLE. `busy` is high for the whole pass
// (RUN + DRAIN). `done` pulses for exactly one cycle after the last output
// write. The next `start` is accepted in the IDLE cycle after `done`, at the
// earliest.
//
// Optional feature (macro FC_CYCLE_CNT_EN): adds the 32-bit `cycle_count`
// output. It counts busy cycles, clears when a pass is accepted, holds after
// `done`, and saturates at 2^32-1.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   start                     one-cycle pass request (ignored unless IDLE)
//   busy, done                pass status / completion pulse
//   in_neuron_rden            read enable, ports a/b of all input banks
//   in_neuron_addr_a/_b       bank address, port a even, port b odd
//   fc_weight_rden            weight read enable, ports a/b
//   fc_weight_addr_a/_b       weight address 2*i / 2*i+1
//   in_neuron_q_a_all/_b_all  packed read data of all PI banks
//   in_neuron_q_a_mux/_b_mux  selected operand (0 when no valid data)
//   enable_mult               MAC input valid
//   accum_sload               MAC accumulator load (first pair of a group)
//   out_wr, out_addr          output-neuron write strobe and group index
//   cycle_count               busy-cycle counter (FC_CYCLE_CNT_EN only)
//
// Debug: the FSM state is held in `state_q` (type state_t).
// ----------------------------------------------------------------------------
module fc_control_seq #(
  parameter int OUTNEURON     = 10,
  parameter int INNEURON      = 64,
  parameter int PI            = 2,
  parameter int PO            = 2,
  parameter int DATA_WIDTH_FC = 16,
  parameter int RD_LATENCY    = 2,
  parameter int MULT_LATENCY  = 3,
  localparam int NPAIR        = INNEURON / 2,
  localparam int SEG          = NPAIR / PI,
  localparam int NGROUP       = OUTNEURON / PO,
  localparam int AW_IN        = $clog2(2 * SEG),
  localparam int AW_W         = $clog2(INNEURON * NGROUP),
  localparam int OA_W         = (NGROUP > 1) ? $clog2(NGROUP) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          in_neuron_rden,
  output logic [AW_IN-1:0]              in_neuron_addr_a,
  output logic [AW_IN-1:0]              in_neuron_addr_b,
  output logic                          fc_weight_rden,
  output logic [AW_W-1:0]               fc_weight_addr_a,
  output logic [AW_W-1:0]               fc_weight_addr_b,
  input  logic [DATA_WIDTH_FC*PI-1:0]   in_neuron_q_a_all,
  input  logic [DATA_WIDTH_FC*PI-1:0]   in_neuron_q_b_all,
  output logic [DATA_WIDTH_FC-1:0]      in_neuron_q_a_mux,
  output logic [DATA_WIDTH_FC-1:0]      in_neuron_q_b_mux,
  output logic                          enable_mult,
  output logic                          accum_sload,
  output logic                          out_wr,
  output logic [OA_W-1:0]               out_addr
`ifdef FC_CYCLE_CNT_EN
  ,
  output logic [31:0]                   cycle_count
`endif
);

  localparam int NISSUE  = NPAIR * NGROUP;
  localparam int TOT_LAT = RD_LATENCY + MULT_LATENCY;
  localparam int SEL_W   = (PI > 1) ? $clog2(PI) : 1;
  localparam int P_W     = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int DR_W    = (TOT_LAT > 1) ? $clog2(TOT_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Issue-side counters: pair within group, group, position within a bank
  // segment, bank index, and the flat issue index i = g*NPAIR + p.
  logic [P_W-1:0]   pair_q;
  logic [OA_W-1:0]  grp_q;
  logic [AW_IN-1:0] seg_off_q;
  logic [SEL_W-1:0] bank_q;
  logic [AW_W-1:0]  iss_q;
  logic [DR_W-1:0]  drain_q;

  logic issue_vld;
  logic pair_first;
  logic pair_last;
  logic issue_last;
  logic drain_last;

  assign issue_vld  = (state_q == S_RUN);
  assign pair_first = (pair_q == '0);
  assign pair_last  = (pair_q == P_W'(NPAIR - 1));
  assign issue_last = (iss_q == AW_W'(NISSUE - 1));
  assign drain_last = (drain_q == DR_W'(TOT_LAT - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue counters. They advance once per RUN cycle and sit at zero otherwise,
  // so every pass starts from slot 0 without an explicit load.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pair_q    <= '0;
      grp_q     <= '0;
      seg_off_q <= '0;
      bank_q    <= '0;
      iss_q     <= '0;
    end else if (issue_vld) begin
      iss_q <= iss_q + AW_W'(1);
      if (pair_last) begin
        pair_q <= '0;
        grp_q  <= grp_q + OA_W'(1);
      end else begin
        pair_q <= pair_q + P_W'(1);
      end
      // Pair p maps to bank p/SEG at offset p mod SEG. NPAIR = SEG*PI, so the
      // bank counter wraps at the same time as the pair counter.
      if (seg_off_q == AW_IN'(SEG - 1)) begin
        seg_off_q <= '0;
        bank_q    <= (bank_q == SEL_W'(PI - 1)) ? '0 : bank_q + SEL_W'(1);
      end else begin
        seg_off_q <= seg_off_q + AW_IN'(1);
      end
    end else begin
      pair_q    <= '0;
      grp_q     <= '0;
      seg_off_q <= '0;
      bank_q    <= '0;
      iss_q     <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_q <= '0;
    end else if (state_q == S_DRAIN) begin
      drain_q <= drain_q + DR_W'(1);
    end else begin
      drain_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Read-side and write-side delay lines. Stage 0 captures the issue-cycle
  // value, so stage D-1 presents it D cycles after issue.
  // --------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [RD_LATENCY-1:0] rd_first_q;
  logic [SEL_W-1:0]      rd_sel_q [RD_LATENCY];
  logic [TOT_LAT-1:0]    wr_tag_q;
  logic [OA_W-1:0]       wr_grp_q [TOT_LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q   <= '0;
      rd_first_q <= '0;
      wr_tag_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) rd_sel_q[k] <= '0;
      for (int k = 0; k < TOT_LAT; k++)    wr_grp_q[k] <= '0;
    end else begin
      rd_vld_q[0]   <= issue_vld;
      rd_first_q[0] <= issue_vld & pair_first;
      rd_sel_q[0]   <= bank_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        rd_vld_q[k]   <= rd_vld_q[k-1];
        rd_first_q[k] <= rd_first_q[k-1];
        rd_sel_q[k]   <= rd_sel_q[k-1];
      end
      wr_tag_q[0] <= issue_vld & pair_last;
      wr_grp_q[0] <= grp_q;
      for (int k = 1; k < TOT_LAT; k++) begin
        wr_tag_q[k] <= wr_tag_q[k-1];
        wr_grp_q[k] <= wr_grp_q[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_neuron_rden   = issue_vld;
  assign fc_weight_rden   = issue_vld;
  assign in_neuron_addr_a = issue_vld ? (seg_off_q << 1) : '0;
  assign in_neuron_addr_b = issue_vld ? ((seg_off_q << 1) | AW_IN'(1)) : '0;
  assign fc_weight_addr_a = issue_vld ? (iss_q << 1) : '0;
  assign fc_weight_addr_b = issue_vld ? ((iss_q << 1) | AW_W'(1)) : '0;

  assign enable_mult = rd_vld_q[RD_LATENCY-1];
  assign accum_sload = rd_first_q[RD_LATENCY-1];
  assign out_wr      = wr_tag_q[TOT_LAT-1];
  assign out_addr    = out_wr ? wr_grp_q[TOT_LAT-1] : '0;

  // Operand mux. It is forced to zero when no valid data is returning, so the
  // MAC never sees stale bank contents.
  always_comb begin
    in_neuron_q_a_mux = '0;
    in_neuron_q_b_mux = '0;
    if (enable_mult) begin
      for (int k = 0; k < PI; k++) begin
        if (rd_sel_q[RD_LATENCY-1] == SEL_W'(k)) begin
          in_neuron_q_a_mux = in_neuron_q_a_all[k*DATA_WIDTH_FC +: DATA_WIDTH_FC];
          in_neuron_q_b_mux = in_neuron_q_b_all[k*DATA_WIDTH_FC +: DATA_WIDTH_FC];
        end
      end
    end
  end

`ifdef FC_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  // Cleared on pass acceptance. Counts only while busy, so the value from the
  // last pass is held through DONE and IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cycle_cnt_q <= '0;
    end else if (busy && cycle_cnt_q != 32'hFFFF_FFFF) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: doc/fc_control_seq.md
Name: fc_control_seq

Overview:
- Parametrised fully-connected layer sequencer; next generation of the FC control block.
- Sequences one FC layer pass after a `start` pulse: address generation for input-neuron and weight M9K pairs (ports a/b), generic PI-way input-bank mux, accumulator load/enable strobes, output-neuron write strobes, `busy`/`done` handshake.
- Sits between the FC buffers and the PO-wide MAC array, replacing the fixed two-bank, free-running controller.

Parameters:
- OUTNEURON, 10, output neurons per layer; must be a multiple of PO.
- INNEURON, 64, input neurons; must be a multiple of 2*PI.
- PI, 2, input-neuron banks muxed onto the MAC input; any value >= 1.
- PO, 2, output neurons computed in parallel per group.
- DATA_WIDTH_FC, 16, neuron data width.
- RD_LATENCY, 2, M9K read latency in cycles, >= 1.
- MULT_LATENCY, 3, cycles from MAC input to accumulated result valid, >= 1.
- Derived localparams: NPAIR=INNEURON/2, SEG=NPAIR/PI, NGROUP=OUTNEURON/PO.
- All counter and address widths are derived with $clog2.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run one layer pass.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at pass completion.
- in_neuron_rden  out  1  read enable, ports a and b of all PI banks.
- in_neuron_addr_a  out  clog2(2*SEG)  bank port-a address.
- in_neuron_addr_b  out  clog2(2*SEG)  bank port-b address.
- fc_weight_rden  out  1  weight read enable, ports a and b.
- fc_weight_addr_a  out  clog2(INNEURON*NGROUP)  weight port-a address.
- fc_weight_addr_b  out  clog2(INNEURON*NGROUP)  weight port-b address.
- in_neuron_q_a_all  in  DATA_WIDTH_FC*PI  port-a read data of all banks; bank k occupies bits [k*DATA_WIDTH_FC +: DATA_WIDTH_FC].
- in_neuron_q_b_all  in  DATA_WIDTH_FC*PI  port-b read data of all banks, same packing.
- in_neuron_q_a_mux  out  DATA_WIDTH_FC  selected port-a operand.
- in_neuron_q_b_mux  out  DATA_WIDTH_FC  selected port-b operand.
- enable_mult  out  1  MAC input valid.
- accum_sload  out  1  MAC accumulator load (first pair of a group).
- out_wr  out  1  output-neuron write strobe.
- out_addr  out  clog2(NGROUP)  output group index written.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset is asynchronous and overrides everything, including mid-pass: pipelines are flushed and no `done` is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when `start`=1.
  - RUN -> DRAIN after issue index NPAIR*NGROUP-1.
  - DRAIN lasts exactly RD_LATENCY+MULT_LATENCY cycles, then -> DONE.
  - DONE lasts one cycle with `done`=1, then -> IDLE.
  - `start` is ignored outside IDLE. `start` in the DONE cycle is also ignored.
- RUN issues one pair per cycle with no gaps. Issue index i = g*NPAIR + p, where g is the group and p is the pair, 0 <= p < NPAIR.
- During RUN, `in_neuron_rden` and `fc_weight_rden` are 1. Outside RUN they are 0 and addresses hold at 0.
- Address mapping:
  - in_neuron_addr_a = 2*(p mod SEG); in_neuron_addr_b = addr_a + 1.
  - fc_weight_addr_a = 2*i; fc_weight_addr_b = 2*i + 1.
- Bank select s = p / SEG. s is delayed RD_LATENCY cycles so the mux selects data returning for that issue.
- Mux outputs are registered-free combinational from the delayed select. When the delayed valid is 0, both mux outputs are 0.
- enable_mult: issue-valid delayed RD_LATENCY cycles.
- accum_sload: (p==0) delayed RD_LATENCY cycles, qualified by valid.
- out_wr: asserted for one cycle when (p==NPAIR-1) is delayed RD_LATENCY+MULT_LATENCY cycles. out_addr = g delayed the same amount.
- Exactly NGROUP `out_wr` pulses occur per pass. The last one falls on the final DRAIN cycle, and `done` follows in the next cycle.
- Pass length, from the first RUN cycle to `done`: NPAIR*NGROUP + RD_LATENCY + MULT_LATENCY cycles, then `done`.
- Back-to-back passes: minimum gap between `done` and the next accepted `start` is 1 cycle (the IDLE cycle).

Optional Feature:
- Macro: FC_CYCLE_CNT_EN.
- When defined, add output `cycle_count` [31:0]:
  - Counts clock cycles while `busy`=1.
  - Cleared on the cycle IDLE -> RUN.
  - Holds its value after `done` until the next start.
  - Saturates at 2^32-1.
  - Reset value is 0.
- When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- INNEURON=8, PI=2, OUTNEURON=4, PO=2 (NPAIR=4, SEG=2, NGROUP=2), defaults otherwise; start at cycle 0 ->
  - RUN cycles 1..8;
  - in_neuron_addr_a sequence 0,2,0,2,0,2,0,2;
  - fc_weight_addr_a sequence 0,2,...,14;
  - out_wr at cycles 9 (out_addr 0) and 13 (out_addr 1);
  - done at cycle 14.
- Same configuration, bank 0 data 0x0011 and bank 1 data 0x0022 -> in_neuron_q_a_mux = 0x0011 at cycles 3,4,7,8 and 0x0022 at cycles 5,6,9,10; accum_sload=1 at cycles 3 and 7 only.
- start pulsed at cycles 0 and 5 -> second start ignored; exactly 2 out_wr pulses and 1 done.
- reset_n low at cycle 6 of a pass -> all outputs 0 asynchronously; no done; a new start after release completes a normal pass.
- PI=4, INNEURON=16 -> select cycles through banks 0,1,2,3 with 2 pairs each per group; mux output 0 when enable_mult=0.
- FC_CYCLE_CNT_EN defined, first test configuration -> cycle_count = 13 after done; it holds 13 until the next start and then clears to 0.
